// File: rtl/btn_conditioner.sv
// btn_conditioner: five-channel push-button front end for the tile-sort game.
// Each channel is synchronised (2 FFs), debounced with a run-length counter and
// turned into one-cycle press/release pulses. All outputs are registered.
// Optional feature: define BTN_REPEAT_EN to compile in per-channel auto-repeat
// of btn_press while a button is held. Without it, no repeat counters exist.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int            CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 1 ||
      REPEAT_RATE > REPEAT_DELAY) begin : g_param_check
    $error("btn_conditioner: illegal timing parameters");
  end

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] rpt_fire;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

  // Two-flop synchroniser; sync2_q is the only view of btn_in downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, flip level at terminal count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_TC) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int            RW         = $clog2(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_TC     = RW'(REPEAT_DELAY - 1);
  // After a repeat the counter restarts here so the next one lands REPEAT_RATE later.
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

  logic [RW-1:0] rpt_q [N_BTN];
  logic [RW-1:0] rpt_d [N_BTN];

  // Repeat counter runs only while the level stays high; cleared on press and release.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_d[i] = '0;
      if (level_q[i] && level_d[i]) begin
        if (rpt_q[i] == RPT_TC) begin
          rpt_fire[i] = 1'b1;
          rpt_d[i]    = RPT_RELOAD;
        end else begin
          rpt_d[i] = rpt_q[i] + RW'(1);
        end
      end
    end
  end

  // Repeat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) rpt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) rpt_q[i] <= rpt_d[i];
    end
  end
`else
  // No auto-repeat: press pulses come only from debounced rising edges.
  always_comb begin
    rpt_fire = '0;
  end
`endif

  // Edge detection on the debounced level, merged with repeat pulses.
  always_comb begin
    press_d   = (level_d & ~level_q) | rpt_fire;
    release_d = level_q & ~level_d;
  end

  // Output pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
